mem_lsu: RTL and testbench

//  MEM-stage load/store unit; sits between EX_MEM and MEM_WB and produces the mem_out word MEM_WB captures.

---
 rtl/mem_lsu.sv | 161 ++++++++++++++++
 tb/tb_mem_lsu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack handshake with a variable-latency data memory,
// store lane steering and load right-alignment. Stalls the pipeline while an access is open.
module mem_lsu #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 zero,
  input  logic                 valid_in,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           Size,
  input  logic [ADDR_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] store_data,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_BITS-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [DATA_BITS-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [DATA_BITS-1:0] dmem_rdata,
  output logic [DATA_BITS-1:0] mem_out,
  output logic                 stall_req,
  output logic                 addr_err,
  output logic                 bus_err
);

  localparam int CNT_BITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg;
  logic [1:0]          off_reg;
  logic [1:0]          size_reg;

  logic [1:0]           off;
  logic                 size_byte, size_half;
  logic                 aligned, start, timeout_hit;
  logic [3:0]           lane_be;
  logic [DATA_BITS-1:0] wdata_next;
  logic [DATA_BITS-1:0] rd_shift;
  logic [DATA_BITS-1:0] load_word;

  assign off       = alu_out[1:0];
  assign size_byte = (Size == 2'b01);
  assign size_half = (Size == 2'b10);
  assign aligned   = size_byte | (size_half & ~off[0]) | (~size_byte & ~size_half & (off == 2'b00));

  // Lanes touched by the access; loads use the same enables as stores.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_be[gi] = size_byte ? (off == 2'(gi)) :
                           size_half ? (off[1] == (gi >= 2)) : 1'b1;
    end
  endgenerate

  always_comb begin
    wdata_next = store_data;
    if (size_byte)
      wdata_next = {4{store_data[7:0]}};
    else if (size_half)
      wdata_next = {2{store_data[15:0]}};
  end

  // Half accesses are even-aligned, so the shift is 0 or 16 for them.
  assign rd_shift = dmem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_word = dmem_rdata;
    if (size_reg == 2'b01)
      load_word = {{(DATA_BITS-8){1'b0}}, rd_shift[7:0]};
    else if (size_reg == 2'b10)
      load_word = {{(DATA_BITS-16){1'b0}}, rd_shift[15:0]};
  end

  assign timeout_hit = (cnt_reg == CNT_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (zero)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    addr_err   = 1'b0;
    stall_req  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_in && (MemRead || MemWrite)) begin
          if (aligned) begin
            start      = 1'b1;
            stall_req  = 1'b1;
            state_next = REQ;
          end else begin
            addr_err = 1'b1;
          end
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (dmem_ack || timeout_hit)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (zero) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      mem_out    <= '0;
      bus_err    <= 1'b0;
      cnt_reg    <= '0;
      off_reg    <= '0;
      size_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {alu_out[ADDR_BITS-1:2], 2'b00};
            dmem_be    <= lane_be;
            dmem_wdata <= wdata_next;
            off_reg    <= off;
            size_reg   <= Size;
            cnt_reg    <= '0;
          end
        end
        REQ: begin
          // An ack on the last allowed cycle still completes normally.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we)
              mem_out <= load_word;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            mem_out  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalignment, timeout and mid-access reset,
// each step checked with an immediate assertion.
module tb_mem_lsu;

  logic        clk;
  logic        zero;
  logic        valid_in;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_out;
  logic        stall_req;
  logic        addr_err;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  mem_lsu #(.DATA_BITS(32), .ADDR_BITS(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .zero       (zero),
    .valid_in   (valid_in),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Size       (Size),
    .alu_out    (alu_out),
    .store_data (store_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mem_out    (mem_out),
    .stall_req  (stall_req),
    .addr_err   (addr_err),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero = 1'b1; valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
    alu_out = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    zero = 1'b0;
    tick();
    chk("idle_stall", {31'd0, stall_req}, 32'd0);

    // 1: load word 0x100, ack on first REQ cycle
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b00; alu_out = 32'h100; #1;
    chk("t1_stall_start", {31'd0, stall_req}, 32'd1);
    chk("t1_req_idle", {31'd0, dmem_req}, 32'd0);
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    chk("t1_req", {31'd0, dmem_req}, 32'd1);
    chk("t1_addr", dmem_addr, 32'h100);
    chk("t1_be", {28'd0, dmem_be}, 32'hF);
    chk("t1_we", {31'd0, dmem_we}, 32'd0);
    chk("t1_stall_req", {31'd0, stall_req}, 32'd1);
    tick(); dmem_ack = 1'b0; #1;
    chk("t1_done_mem_out", mem_out, 32'hDEADBEEF);
    chk("t1_done_stall", {31'd0, stall_req}, 32'd0);
    chk("t1_done_req", {31'd0, dmem_req}, 32'd0);
    valid_in = 1'b0; MemRead = 1'b0;
    tick();
    chk("t1_bubble_stall", {31'd0, stall_req}, 32'd0);
    chk("t1_bubble_hold", mem_out, 32'hDEADBEEF);

    // 2: load byte 0x203, ack after 3 wait cycles (last cycle before timeout)
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b01; alu_out = 32'h203; #1;
    chk("t2_stall_start", {31'd0, stall_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h80112233; end
      #1;
      chk("t2_req", {31'd0, dmem_req}, 32'd1);
      chk("t2_be", {28'd0, dmem_be}, 32'h8);
      chk("t2_addr", dmem_addr, 32'h200);
      chk("t2_stall", {31'd0, stall_req}, 32'd1);
    end
    tick(); dmem_ack = 1'b0; valid_in = 1'b0; MemRead = 1'b0; #1;
    chk("t2_mem_out", mem_out, 32'h00000080);
    chk("t2_done_stall", {31'd0, stall_req}, 32'd0);
    chk("t2_done_bus_err", {31'd0, bus_err}, 32'd0);
    tick();

    // 3: store half 0x402, ack immediately
    valid_in = 1'b1; MemWrite = 1'b1; Size = 2'b10; alu_out = 32'h402; store_data = 32'h0000ABCD; #1;
    chk("t3_stall_start", {31'd0, stall_req}, 32'd1);
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF; #1;
    chk("t3_be", {28'd0, dmem_be}, 32'hC);
    chk("t3_wdata", dmem_wdata, 32'hABCDABCD);
    chk("t3_we", {31'd0, dmem_we}, 32'd1);
    chk("t3_addr", dmem_addr, 32'h400);
    tick(); dmem_ack = 1'b0; valid_in = 1'b0; MemWrite = 1'b0; #1;
    chk("t3_mem_out_held", mem_out, 32'h00000080);
    chk("t3_done_req", {31'd0, dmem_req}, 32'd0);
    tick();

    // 6: reset during second REQ cycle, late ack ignored, then normal load
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b00; alu_out = 32'h500; #1;
    tick(); #1;
    chk("t6_req1", {31'd0, dmem_req}, 32'd1);
    tick(); zero = 1'b1; #1;
    chk("t6_req2", {31'd0, dmem_req}, 32'd1);
    tick(); zero = 1'b0; valid_in = 1'b0; MemRead = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA; #1;
    chk("t6_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("t6_rst_addr", dmem_addr, 32'd0);
    chk("t6_rst_be", {28'd0, dmem_be}, 32'd0);
    chk("t6_rst_mem_out", mem_out, 32'd0);
    chk("t6_rst_stall", {31'd0, stall_req}, 32'd0);
    tick(); dmem_ack = 1'b0; #1;
    chk("t6_late_ack_mem_out", mem_out, 32'd0);
    chk("t6_late_ack_req", {31'd0, dmem_req}, 32'd0);
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b00; alu_out = 32'h600; #1;
    chk("t6_new_stall", {31'd0, stall_req}, 32'd1);
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'h12345678; #1;
    chk("t6_new_addr", dmem_addr, 32'h600);
    tick(); dmem_ack = 1'b0; valid_in = 1'b0; MemRead = 1'b0; #1;
    chk("t6_new_mem_out", mem_out, 32'h12345678);
    tick();

    // 4: misaligned accesses flag addr_err and do not start
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b00; alu_out = 32'h101; #1;
    chk("t4_addr_err", {31'd0, addr_err}, 32'd1);
    chk("t4_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("t4_req", {31'd0, dmem_req}, 32'd0);
    chk("t4_addr_err_idle", {31'd0, addr_err}, 32'd1);
    Size = 2'b10; alu_out = 32'h103; #1;
    chk("t4_half_err", {31'd0, addr_err}, 32'd1);
    Size = 2'b01; #1;
    chk("t4_byte_ok", {31'd0, addr_err}, 32'd0);
    chk("t4_byte_stall", {31'd0, stall_req}, 32'd1);
    valid_in = 1'b0; #1;
    chk("t4_bubble_err", {31'd0, addr_err}, 32'd0);
    tick();

    // 5: no ack, timeout after 4 REQ cycles
    valid_in = 1'b1; MemRead = 1'b1; Size = 2'b00; alu_out = 32'h300; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("t5_req", {31'd0, dmem_req}, 32'd1);
      chk("t5_bus_err_req", {31'd0, bus_err}, 32'd0);
    end
    tick(); valid_in = 1'b0; MemRead = 1'b0; #1;
    chk("t5_done_req", {31'd0, dmem_req}, 32'd0);
    chk("t5_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t5_mem_out", mem_out, 32'd0);
    chk("t5_done_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("t5_bus_err_clr", {31'd0, bus_err}, 32'd0);
    chk("t5_idle_req", {31'd0, dmem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
